// File: rtl/run_ctrl_pkg.sv
// Shared types for run_ctrl: FSM state encoding, mode codes and sizing helpers.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StHalt  = 2'd1,
    StRun   = 2'd2,
    StBurst = 2'd3
  } run_state_e;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_HALT  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // Counter only needs to reach hold-1 before leaving the reset state.
  function automatic int unsigned rst_cnt_width(input int unsigned hold);
    return (hold > 2) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running clock-enable divider: tick_o pulses once every (div_i + 1) cycles.
module ce_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign tick_o = (div_cnt_q == div_i);

  // A shrunken div leaves the count above the limit; wrap straight back to 0.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (div_cnt_q >= div_i) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Core run controller: reset sequencing, run/halt/step/burst gating of the core clock enable.
// Define BREAKPOINT_EN to add the PC breakpoint comparator and sticky hit flag.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  input  logic             hit_clr,
  output logic             cpu_ce,
  output logic             core_reset,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             hit
);

  localparam int unsigned RstW = rst_cnt_width(RST_HOLD);

  run_state_e       state_q, state_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             step_pend_q, step_pend_d;
  logic             ce_q, ce_d;
  logic             core_reset_q, core_reset_d;
  logic             tick;
  logic             bp_match;
  logic             bp_stop;
  logic             leave_halt;
  logic             step_arm;

  ce_divider #(
    .DIV_W (DIV_W)
  ) u_ce_divider (
    .clk_i  (clk_in),
    .rst_i  (reset),
    .div_i  (div),
    .tick_o (tick)
  );

`ifdef BREAKPOINT_EN
  logic skip_q, skip_d;
  logic hit_q, hit_d;

  assign bp_match = bp_valid && (pc == bp_addr) && !skip_q;
`else
  assign bp_match = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    step_pend_d  = step_pend_q;
    ce_d         = 1'b0;
    core_reset_d = 1'b0;
    bp_stop      = 1'b0;
    leave_halt   = 1'b0;
    step_arm     = 1'b0;

    unique case (state_q)
      StReset: begin
        core_reset_d = 1'b1;
        if (32'(rst_cnt_q) + 32'd1 >= RST_HOLD) begin
          state_d      = StHalt;
          core_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end

      StHalt: begin
        if (tick && step_pend_q) begin
          step_pend_d = 1'b0;
          if (bp_match) begin
            bp_stop = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
        end
        // A request landing on the consuming cycle re-arms; one arriving while pending is lost.
        if (mode == MODE_STEP && step_req && !step_pend_d) begin
          step_pend_d = 1'b1;
          step_arm    = 1'b1;
        end
        if (mode == MODE_RUN) begin
          state_d    = StRun;
          leave_halt = 1'b1;
        end else if (mode == MODE_BURST && step_req && burst_len != '0) begin
          state_d     = StBurst;
          burst_cnt_d = burst_len;
          leave_halt  = 1'b1;
        end
        if (leave_halt) begin
          step_pend_d = 1'b0;
        end
      end

      StRun: begin
        if (tick) begin
          if (bp_match) begin
            bp_stop = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
        end
        if (bp_stop || mode != MODE_RUN) begin
          state_d = StHalt;
        end
      end

      StBurst: begin
        if (mode == MODE_HALT) begin
          state_d     = StHalt;
          burst_cnt_d = '0;
        end else if (tick) begin
          if (bp_match) begin
            bp_stop     = 1'b1;
            state_d     = StHalt;
            burst_cnt_d = '0;
          end else begin
            ce_d        = 1'b1;
            burst_cnt_d = burst_cnt_q - CNT_W'(1);
            if (burst_cnt_q == CNT_W'(1)) begin
              state_d = StHalt;
            end
          end
        end
      end

      default: begin
        state_d = StReset;
      end
    endcase

    cycle_cnt_d = cycle_cnt_q + CNT_W'(ce_d);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= StReset;
      rst_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      cycle_cnt_q  <= '0;
      step_pend_q  <= 1'b0;
      ce_q         <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      step_pend_q  <= step_pend_d;
      ce_q         <= ce_d;
      core_reset_q <= core_reset_d;
    end
  end

`ifdef BREAKPOINT_EN
  // skip lets the instruction that tripped the breakpoint execute once on resume.
  always_comb begin
    skip_d = skip_q;
    if (leave_halt || step_arm) begin
      skip_d = 1'b1;
    end else if (ce_d) begin
      skip_d = 1'b0;
    end
    hit_d = hit_q;
    if (hit_clr) begin
      hit_d = 1'b0;
    end
    if (bp_stop) begin
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      skip_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      skip_q <= skip_d;
      hit_q  <= hit_d;
    end
  end

  assign hit = hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid, hit_clr, bp_stop, leave_halt, step_arm};
  assign hit       = 1'b0;
`endif

  assign cpu_ce     = ce_q;
  assign core_reset = core_reset_q;
  assign state      = state_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of clock-enable divide ratio.
REQ-002 SHALL have parameter PC_W, default 32, width of core program counter.
REQ-003 SHALL have parameter CNT_W, default 32, width of cycle and burst counters.
REQ-004 SHALL have parameter RST_HOLD, default 4, clk_in cycles core_reset stays high after reset release.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have these ports, in this order (name, direction, width, meaning):
- clk_in, input, 1, sole clock.
- reset, input, 1, async active-high reset.
- div, input, DIV_W, cpu_ce period minus one.
- mode, input, 2: 00 RUN, 01 HALT, 10 STEP, 11 BURST.
- step_req, input, 1, single-cycle request pulse.
- burst_len, input, CNT_W, enables granted per BURST request.
- pc, input, PC_W, current core PC.
- bp_addr, input, PC_W, breakpoint address.
- bp_valid, input, 1, breakpoint armed.
- hit_clr, input, 1, clears hit.
- cpu_ce, output, 1, core clock enable.
- core_reset, output, 1, core reset.
- state, output, 2, FSM state.
- cycle_cnt, output, CNT_W, count of asserted cpu_ce.
- hit, output, 1, sticky breakpoint flag.

Function
REQ-007 SHALL keep div_cnt, counting 0..div and wrapping to 0; tick is high when div_cnt==div; div==0 gives tick every cycle.
REQ-008 SHALL take a change of div effect only at the next wrap; if div_cnt>div, div_cnt SHALL wrap to 0 on the next cycle.
REQ-009 SHALL implement four FSM states: RESET=0, HALT=1, RUN=2, BURST=3.
REQ-010 In RESET, the block SHALL hold core_reset high and cpu_ce low for RST_HOLD cycles, then enter HALT.
REQ-011 In HALT, mode RUN SHALL go to RUN.
REQ-012 In HALT, mode BURST with step_req SHALL load the burst counter with burst_len and go to BURST; burst_len==0 SHALL stay in HALT.
REQ-013 In HALT, mode STEP with step_req SHALL set step_pend.
REQ-014 In HALT, cpu_ce SHALL be tick & step_pend; step_pend SHALL clear on that cycle.
REQ-015 In RUN, cpu_ce SHALL equal tick; mode≠RUN SHALL return to HALT at the next cycle.
REQ-016 In BURST, cpu_ce SHALL equal tick; the counter SHALL decrement per cpu_ce; reaching 0 SHALL go to HALT.
REQ-017 In BURST, mode HALT SHALL abort to HALT immediately, and the counter SHALL clear.
REQ-018 A step_req in the same cycle as the step_pend clear SHALL re-set step_pend; pulses arriving while pending SHALL be dropped.
REQ-019 cycle_cnt SHALL increment per cpu_ce and wrap modulo 2^CNT_W.
REQ-020 cpu_ce and core_reset SHALL be registered outputs (one-cycle latency from FSM decision).

Reset
REQ-021 Asserting reset SHALL immediately give: state=RESET, core_reset=1, cpu_ce=0, cycle_cnt=0, hit=0, div_cnt=0, step_pend=0, skip=0, burst counter=0.
REQ-022 Assertion mid-BURST or mid-RUN SHALL abort with no further cpu_ce.

Configuration
REQ-023 With BREAKPOINT_EN defined: on a tick in RUN/BURST/step where bp_valid and pc==bp_addr and skip==0, cpu_ce SHALL be suppressed, state SHALL go to HALT, and hit SHALL be set.
REQ-024 With BREAKPOINT_EN defined: skip SHALL set on every exit from HALT and clear after the first granted cpu_ce, so resume executes the breakpointed instruction.
REQ-025 With BREAKPOINT_EN defined: hit SHALL clear on hit_clr; a simultaneous set SHALL win.
REQ-026 Without BREAKPOINT_EN: pc, bp_addr, bp_valid and hit_clr SHALL be ignored, hit SHALL be tied 0, and there SHALL be no comparator logic.

Structure
REQ-027 Package run_ctrl_pkg SHALL hold state encodings, mode codes MODE_RUN/HALT/STEP/BURST.
REQ-028 Sub-module ce_divider (div_cnt, tick, REQ-007/008) SHALL be instantiated once.

Verification
REQ-029 Reset 1 for 100 ns, release: core_reset=1 exactly 4 cycles, state=HALT, cpu_ce=0.
REQ-030 div=3, mode=RUN for 40 cycles: cpu_ce every 4th cycle, cycle_cnt=10.
REQ-031 mode=STEP, three step_req pulses 10 cycles apart, div=0: exactly 3 cpu_ce, cycle_cnt=3, state stays HALT.
REQ-032 burst_len=5, mode=BURST with step_req, div=1: 5 cpu_ce on alternate cycles, then HALT; repeat with mode=HALT after 2 enables gives 2 enables.
REQ-033 With BREAKPOINT_EN defined, bp_addr=0x0000_0010, pc steps by 4 per cpu_ce from 0: 4 enables, hit=1, HALT; RUN resumes with 5th enable at pc 0x10.
REQ-034 Reset asserted mid-BURST (burst_len=100, after 7 enables): cpu_ce low immediately, cycle_cnt=0, no further enables.
